// File: rtl/fifo_pkt_pkg.sv
// Shared types and header field positions for the packet reader.
// FIFO_PKT_LEN_CHK_EN (see fifo_pkt_reader.sv) selects zero-length header handling.
package fifo_pkt_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } pkt_state_e;

  // Payload word count sits in the low bits of the header word
  localparam int unsigned HDR_LEN_LSB = 0;

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// FIFO-side and stream-side signal bundle for fifo_pkt_reader.
// master = the reader itself, slave = the surrounding FIFO/sink environment.
interface fifo_pkt_reader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_sop;
  logic                  m_eop;
  logic                  m_ready;
  logic [CNT_WIDTH-1:0]  pkt_cnt;
  logic [CNT_WIDTH-1:0]  err_cnt;

  modport master (
    input  fifo_dout, fifo_empty, m_ready,
    output fifo_rd_en, m_data, m_valid, m_sop, m_eop, pkt_cnt, err_cnt
  );

  modport slave (
    output fifo_dout, fifo_empty, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_sop, m_eop, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/fifo_pkt_out_stage.sv
// Single output register for the packet stream; holds data/sop/eop while the
// downstream stalls and drops valid once a beat is taken with nothing new loaded.
module fifo_pkt_out_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sop,
  output logic                  o_eop
);
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_sop;
  logic                  r_eop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;
endmodule

// File: rtl/fifo_pkt_reader.sv
// Reads length-prefixed packets from an FWFT FIFO and emits a sop/eop stream.
// Define FIFO_PKT_LEN_CHK_EN to drop zero-length headers and count them in err_cnt.
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 12,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic            clk,
  input logic            rst,
  fifo_pkt_reader_if.master bus
);
  pkt_state_e            r_state;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;

  logic                  w_pop;
  logic                  w_load;
  logic                  w_sop;
  logic                  w_eop;
  logic                  w_zero_len;
  logic                  w_last;
  logic [LEN_WIDTH-1:0]  w_len;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_out_sop;
  logic                  w_out_eop;

  assign w_len      = bus.fifo_dout[HDR_LEN_LSB +: LEN_WIDTH];
  assign w_zero_len = (w_len == '0);
  assign w_last     = (r_remaining == LEN_WIDTH'(1));
  assign w_pop      = !rst && !bus.fifo_empty && (!w_valid || bus.m_ready);
  assign bus.fifo_rd_en = w_pop;

  always_comb begin
    w_sop = (r_state == ST_IDLE);
    w_eop = (r_state == ST_IDLE) ? w_zero_len : w_last;
`ifdef FIFO_PKT_LEN_CHK_EN
    // Zero-length header is popped but never reaches the output register
    w_load = w_pop && !((r_state == ST_IDLE) && w_zero_len);
`else
    w_load = w_pop;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_pkt_cnt   <= '0;
    end else begin
      if (w_pop) begin
        if (r_state == ST_IDLE) begin
          if (!w_zero_len) begin
            r_state     <= ST_BODY;
            r_remaining <= w_len;
          end
        end else begin
          r_remaining <= r_remaining - LEN_WIDTH'(1);
          if (w_last) r_state <= ST_IDLE;
        end
      end
      if (w_valid && bus.m_ready && w_out_eop) r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef FIFO_PKT_LEN_CHK_EN
  logic [CNT_WIDTH-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_pop && (r_state == ST_IDLE) && w_zero_len) begin
      r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = '0;
`endif

  fifo_pkt_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (bus.fifo_dout),
    .i_sop   (w_sop),
    .i_eop   (w_eop),
    .i_ready (bus.m_ready),
    .o_valid (w_valid),
    .o_data  (w_data),
    .o_sop   (w_out_sop),
    .o_eop   (w_out_eop)
  );

  assign bus.m_valid = w_valid;
  assign bus.m_data  = w_data;
  assign bus.m_sop   = w_out_sop;
  assign bus.m_eop   = w_out_eop;
  assign bus.pkt_cnt = r_pkt_cnt;
endmodule
